// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/EXEC/MEM/WB control FSM owning PC and r2..r7.
// Optional macro MEM_TIMEOUT_EN adds a per-access mem_ack timeout that traps into FAULT.

module core_sequencer #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter logic [3:0]  FETCH_MODE     = 4'b0001,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        resume,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [3:0]  mem_mode,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] ex_instruction,
  output logic [15:0] ex_pc,
  output logic [95:0] ex_reg_file,
  input  logic [15:0] ex_res,
  input  logic        ex_res_from_ram,
  input  logic [2:0]  ex_res_target,
  input  logic [15:0] ex_ram_addr,
  input  logic        ex_ram_op,
  input  logic [15:0] ex_ram_write,
  input  logic [3:0]  ex_ram_mode,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t      r_state,     w_nxt_state;
  logic [15:0] r_pc,        w_nxt_pc;
  logic [95:0] r_regs,      w_nxt_regs;
  logic [15:0] r_instr,     w_nxt_instr;
  logic [15:0] r_instret,   w_nxt_instret;
  logic        r_mem_req,   w_nxt_mem_req;
  logic        r_mem_we,    w_nxt_mem_we;
  logic [15:0] r_mem_addr,  w_nxt_mem_addr;
  logic [15:0] r_mem_wdata, w_nxt_mem_wdata;
  logic [3:0]  r_mem_mode,  w_nxt_mem_mode;
  logic        r_halted,    w_nxt_halted;
  logic        r_fault,     w_nxt_fault;
  logic [15:0] r_wb_val,    w_nxt_wb_val;
  logic [2:0]  r_wb_tgt,    w_nxt_wb_tgt;
  logic        w_acc_done;
  logic        w_timeout;
  logic [15:0] w_wb_pc;

  assign w_acc_done = r_mem_req & mem_ack;
  assign w_wb_pc    = (r_wb_tgt == 3'd1) ? r_wb_val : r_pc;

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wait;

  // Wait counter idles at zero, so every mem_req rise starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= 16'd0;
    end else if (!r_mem_req) begin
      r_wait <= 16'd0;
    end else if (!mem_ack) begin
      r_wait <= r_wait + 16'd1;
    end else begin
      r_wait <= r_wait;
    end
  end

  assign w_timeout = r_mem_req & ~mem_ack & (r_wait == TIMEOUT_LAST);
`else
  logic [15:0] w_unused_timeout;
  assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
`endif

  // Next-state and next-output logic; the request for the next access is raised on the
  // transition into FETCH/MEM so an immediate ack completes that state in one cycle.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_pc        = r_pc;
    w_nxt_regs      = r_regs;
    w_nxt_instr     = r_instr;
    w_nxt_instret   = r_instret;
    w_nxt_mem_req   = r_mem_req;
    w_nxt_mem_we    = r_mem_we;
    w_nxt_mem_addr  = r_mem_addr;
    w_nxt_mem_wdata = r_mem_wdata;
    w_nxt_mem_mode  = r_mem_mode;
    w_nxt_halted    = r_halted;
    w_nxt_fault     = r_fault;
    w_nxt_wb_val    = r_wb_val;
    w_nxt_wb_tgt    = r_wb_tgt;

    case (r_state)
      S_FETCH: begin
        if (w_acc_done) begin
          w_nxt_instr   = mem_rdata;
          w_nxt_pc      = r_pc + 16'd1;
          w_nxt_mem_req = 1'b0;
          w_nxt_state   = S_EXEC;
        end else if (w_timeout) begin
          w_nxt_mem_req = 1'b0;
          w_nxt_fault   = 1'b1;
          w_nxt_state   = S_FAULT;
        end else if (!r_mem_req) begin
          w_nxt_mem_req  = 1'b1;
          w_nxt_mem_we   = 1'b0;
          w_nxt_mem_addr = r_pc;
          w_nxt_mem_mode = FETCH_MODE;
        end else begin
          w_nxt_state = S_FETCH;
        end
      end

      S_EXEC: begin
        if (r_instr[15:12] == 4'hF) begin
          w_nxt_halted = 1'b1;
          w_nxt_state  = S_HALT;
        end else if (ex_res_from_ram) begin
          w_nxt_mem_req   = 1'b1;
          w_nxt_mem_we    = ex_ram_op;
          w_nxt_mem_addr  = ex_ram_addr;
          w_nxt_mem_wdata = ex_ram_write;
          w_nxt_mem_mode  = ex_ram_mode;
          w_nxt_wb_tgt    = ex_res_target;
          w_nxt_state     = S_MEM;
        end else begin
          w_nxt_wb_val = ex_res;
          w_nxt_wb_tgt = ex_res_target;
          w_nxt_state  = S_WB;
        end
      end

      S_MEM: begin
        if (w_acc_done) begin
          w_nxt_wb_val  = mem_rdata;
          w_nxt_wb_tgt  = r_mem_we ? 3'd0 : r_wb_tgt;
          w_nxt_mem_req = 1'b0;
          w_nxt_state   = S_WB;
        end else if (w_timeout) begin
          w_nxt_mem_req = 1'b0;
          w_nxt_fault   = 1'b1;
          w_nxt_state   = S_FAULT;
        end else begin
          w_nxt_state = S_MEM;
        end
      end

      S_WB: begin
        case (r_wb_tgt)
          3'd1:    w_nxt_pc          = r_wb_val;
          3'd2:    w_nxt_regs[15:0]  = r_wb_val;
          3'd3:    w_nxt_regs[31:16] = r_wb_val;
          3'd4:    w_nxt_regs[47:32] = r_wb_val;
          3'd5:    w_nxt_regs[63:48] = r_wb_val;
          3'd6:    w_nxt_regs[79:64] = r_wb_val;
          3'd7:    w_nxt_regs[95:80] = r_wb_val;
          default: w_nxt_pc          = r_pc;
        endcase
        w_nxt_instret  = r_instret + 16'd1;
        w_nxt_mem_req  = 1'b1;
        w_nxt_mem_we   = 1'b0;
        w_nxt_mem_addr = w_wb_pc;
        w_nxt_mem_mode = FETCH_MODE;
        w_nxt_state    = S_FETCH;
      end

      S_HALT: begin
        if (resume) begin
          w_nxt_halted   = 1'b0;
          w_nxt_mem_req  = 1'b1;
          w_nxt_mem_we   = 1'b0;
          w_nxt_mem_addr = r_pc;
          w_nxt_mem_mode = FETCH_MODE;
          w_nxt_state    = S_FETCH;
        end else begin
          w_nxt_state = S_HALT;
        end
      end

      S_FAULT: begin
        w_nxt_state = S_FAULT;
      end

      default: begin
        w_nxt_mem_req = 1'b0;
        w_nxt_state   = S_FETCH;
      end
    endcase
  end

  // State and datapath registers; every output is driven straight from here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_regs      <= 96'd0;
      r_instr     <= 16'd0;
      r_instret   <= 16'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 16'd0;
      r_mem_wdata <= 16'd0;
      r_mem_mode  <= 4'd0;
      r_halted    <= 1'b0;
      r_fault     <= 1'b0;
      r_wb_val    <= 16'd0;
      r_wb_tgt    <= 3'd0;
    end else begin
      r_state     <= w_nxt_state;
      r_pc        <= w_nxt_pc;
      r_regs      <= w_nxt_regs;
      r_instr     <= w_nxt_instr;
      r_instret   <= w_nxt_instret;
      r_mem_req   <= w_nxt_mem_req;
      r_mem_we    <= w_nxt_mem_we;
      r_mem_addr  <= w_nxt_mem_addr;
      r_mem_wdata <= w_nxt_mem_wdata;
      r_mem_mode  <= w_nxt_mem_mode;
      r_halted    <= w_nxt_halted;
      r_fault     <= w_nxt_fault;
      r_wb_val    <= w_nxt_wb_val;
      r_wb_tgt    <= w_nxt_wb_tgt;
    end
  end

  assign mem_req        = r_mem_req;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign mem_mode       = r_mem_mode;
  assign ex_instruction = r_instr;
  assign ex_pc          = r_pc;
  assign ex_reg_file    = r_regs;
  assign halted         = r_halted;
  assign fault          = r_fault;
  assign instret        = r_instret;

endmodule
